nios_debug_scan_slave: RTL and testbench

Parametrised Nios debug-slave datapath: single-clock capture/shift/update engine behind a virtual-JTAG front end whose state strobes are already in the `clk` domain. Supersedes the fixed 38-bit, 2-bit-IR debug-slave pair with the following additions:

- configurable data-register width, IR width and channel count;
- scan-length checking;
- a valid/ready command handshake toward the CPU debug logic, replacing fire-and-forget action pulses;
- sticky error reporting back through `ir_out`.

---
 rtl/nios_debug_pkg.sv | 17 +
 rtl/nios_debug_scan_chain.sv | 58 +++++
 rtl/nios_debug_scan_slave.sv | 111 +++++++++++
 tb/tb_nios_debug_scan_slave.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_debug_pkg.sv
// Shared types and constants for the Nios debug-slave scan datapath.
package nios_debug_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmd_state_e;

  localparam int unsigned OVR_BIT  = 0;
  localparam int unsigned SERR_BIT = 1;

  // The MSB of the scanned word selects take_action vs take_no_action.
  function automatic int unsigned action_bit(input int unsigned dr_w);
    return dr_w - 1;
  endfunction

endpackage

// File: rtl/nios_debug_scan_chain.sv
// Capture mux, DR shift register and saturating bit counter for the debug scan chain.
module nios_debug_scan_chain
  import nios_debug_pkg::*;
#(
  parameter int unsigned DR_W   = 38,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IR_W   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clr,
  input  logic                   i_cap,
  input  logic                   i_shift,
  input  logic                   i_tdi,
  input  logic [IR_W-1:0]        i_ch,
  input  logic [NUM_CH*DR_W-1:0] i_cap_data,
  output logic [DR_W-1:0]        o_sr,
  output logic                   o_tdo,
  output logic                   o_len_ok
);

  localparam int unsigned     CNT_W   = $clog2(DR_W + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(DR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_W + 1);

  logic [DR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [DR_W-1:0]  w_cap;

  // Out-of-range channels fall through to zero, giving the bypass capture.
  always_comb begin
    w_cap = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (i_ch == IR_W'(c)) w_cap = i_cap_data[c*DR_W +: DR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cap) begin
      r_sr  <= w_cap;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr <= {i_tdi, r_sr[DR_W-1:1]};
      // Saturate one past DR_W so overlong scans never alias to a valid length.
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sr     = r_sr;
  assign o_tdo    = r_sr[0];
  assign o_len_ok = (r_cnt == CNT_LEN);

endmodule

// File: rtl/nios_debug_scan_slave.sv
// Nios debug-slave: IR latch, update arbitration, command handshake FSM and sticky status flags.
module nios_debug_scan_slave
  import nios_debug_pkg::*;
#(
  parameter int unsigned DR_W   = 38,
  parameter int unsigned IR_W   = 2,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vs_uir,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   tdi,
  output logic                   tdo,
  output logic [IR_W-1:0]        ir_out,
  input  logic [NUM_CH*DR_W-1:0] cap_data,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_W-1:0]        cmd_ch,
  output logic                   cmd_action,
  output logic [DR_W-1:0]        cmd_data
);

  localparam int unsigned     ACT_BIT   = action_bit(DR_W);
  localparam logic [IR_W:0]   NUM_CH_EX = (IR_W + 1)'(NUM_CH);

  cmd_state_e       r_state;
  logic [IR_W-1:0]  r_ir_q;
  logic             r_ovr;
  logic             r_serr;
  logic [DR_W-1:0]  r_cmd_data;
  logic [IR_W-1:0]  r_cmd_ch;
  logic             r_cmd_action;

  logic [DR_W-1:0]  w_sr;
  logic             w_len_ok;
  logic             w_ch_ok;
  logic             w_udr;
  logic             w_accept;

  assign w_ch_ok  = ({1'b0, r_ir_q} < NUM_CH_EX);
  assign w_udr    = vs_udr & ~vs_uir & w_ch_ok;
  assign w_accept = w_udr & w_len_ok & ((r_state == IDLE) | cmd_ready);

  nios_debug_scan_chain #(
    .DR_W   (DR_W),
    .NUM_CH (NUM_CH),
    .IR_W   (IR_W)
  ) u_chain (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (vs_uir),
    .i_cap      (vs_cdr & ~vs_uir & ~vs_udr),
    .i_shift    (vs_sdr & ~vs_uir & ~vs_udr & ~vs_cdr),
    .i_tdi      (tdi),
    .i_ch       (r_ir_q),
    .i_cap_data (cap_data),
    .o_sr       (w_sr),
    .o_tdo      (tdo),
    .o_len_ok   (w_len_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ir_q       <= '0;
      r_ovr        <= 1'b0;
      r_serr       <= 1'b0;
      r_cmd_data   <= '0;
      r_cmd_ch     <= '0;
      r_cmd_action <= 1'b0;
    end else begin
      if (vs_uir) begin
        r_ir_q <= ir_in;
        r_ovr  <= 1'b0;
        r_serr <= 1'b0;
      end else if (w_udr) begin
        // Length error takes precedence over overrun for the same dropped update.
        if (!w_len_ok) r_serr <= 1'b1;
        else if ((r_state == PEND) && !cmd_ready) r_ovr <= 1'b1;
      end

      if (w_accept) begin
        r_cmd_data   <= w_sr;
        r_cmd_ch     <= r_ir_q;
        r_cmd_action <= w_sr[ACT_BIT];
      end

      case (r_state)
        IDLE:    if (w_accept) r_state <= PEND;
        PEND:    if (!w_accept && cmd_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ir_out           = '0;
    ir_out[OVR_BIT]  = r_ovr;
    ir_out[SERR_BIT] = r_serr;
  end

  assign cmd_valid  = (r_state == PEND);
  assign cmd_ch     = r_cmd_ch;
  assign cmd_action = r_cmd_action;
  assign cmd_data   = r_cmd_data;

endmodule

// File: tb/tb_nios_debug_scan_slave.sv
// Scoreboard bench for nios_debug_scan_slave: expected commands queued at update, checked at handshake.
module tb_nios_debug_scan_slave;

  localparam int unsigned DR_W   = 38;
  localparam int unsigned IR_W   = 2;
  localparam int unsigned NUM_CH = 3;

  typedef struct packed {
    logic [DR_W-1:0] data;
    logic [IR_W-1:0] ch;
    logic            act;
  } exp_cmd_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   vs_uir = 1'b0, vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0;
  logic [IR_W-1:0]        ir_in = '0;
  logic                   tdi = 1'b0;
  logic                   tdo;
  logic [IR_W-1:0]        ir_out;
  logic [NUM_CH*DR_W-1:0] cap_data = '0;
  logic                   cmd_valid;
  logic                   cmd_ready = 1'b0;
  logic [IR_W-1:0]        cmd_ch;
  logic                   cmd_action;
  logic [DR_W-1:0]        cmd_data;

  int       n_cmp = 0;
  int       n_err = 0;
  exp_cmd_t sb[$];
  exp_cmd_t sb_e;

  nios_debug_scan_slave #(.DR_W(DR_W), .IR_W(IR_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .ir_in(ir_in), .tdi(tdi), .tdo(tdo), .ir_out(ir_out),
    .cap_data(cap_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_action(cmd_action), .cmd_data(cmd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_uir(input logic [IR_W-1:0] ir);
    vs_uir = 1'b1; ir_in = ir;
    tick();
    vs_uir = 1'b0;
  endtask

  task automatic do_cdr();
    vs_cdr = 1'b1;
    tick();
    vs_cdr = 1'b0;
  endtask

  task automatic do_shift(input logic [DR_W-1:0] d, input int n,
                          input bit chk_tdo, input logic [DR_W-1:0] exp_tdo);
    for (int i = 0; i < n; i++) begin
      if (chk_tdo && i < int'(DR_W)) chk($sformatf("tdo[%0d]", i), 64'(tdo), 64'(exp_tdo[i]));
      tdi = (i < int'(DR_W)) ? d[i] : 1'b0;
      vs_sdr = 1'b1;
      tick();
      vs_sdr = 1'b0;
    end
  endtask

  task automatic do_udr(input bit expect_cmd, input logic [DR_W-1:0] d, input logic [IR_W-1:0] ch);
    exp_cmd_t e;
    if (expect_cmd) begin
      e.data = d; e.ch = ch; e.act = d[DR_W-1];
      sb.push_back(e);
    end
    vs_udr = 1'b1;
    tick();
    vs_udr = 1'b0;
  endtask

  // Handshake monitor: the command seen when valid&&ready must match the oldest queued one.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("hs_data", 64'(cmd_data), 64'(sb_e.data));
        chk("hs_ch", 64'(cmd_ch), 64'(sb_e.ch));
        chk("hs_action", 64'(cmd_action), 64'(sb_e.act));
      end
    end
  end

  logic [DR_W-1:0] cap0, cap1, cap2, d_a, d_b, d_c, d_d;

  initial begin
    cap0 = 38'h0F_0F0F_0F0F;
    cap1 = 38'h3A_5A5A_5A58;
    cap2 = 38'h15_5555_5555;
    cap_data = {cap2, cap1, cap0};
    d_a = 38'h12_3456_789B;
    d_b = 38'h0C_CCCC_CCCC;
    d_c = 38'h2F_EDCB_A987;
    d_d = 38'h3F_FFFF_FFFF;

    tick(); tick();
    reset = 1'b0;
    chk("rst_tdo", 64'(tdo), 64'd0);
    chk("rst_ir_out", 64'(ir_out), 64'd0);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_data", 64'(cmd_data), 64'd0);
    chk("rst_ch", 64'(cmd_ch), 64'd0);
    chk("rst_action", 64'(cmd_action), 64'd0);

    // Normal command on channel 1
    do_uir(2'd1); do_cdr();
    do_shift(38'h20_0000_00AB, DR_W, 1'b0, '0);
    do_udr(1'b1, 38'h20_0000_00AB, 2'd1);
    chk("t1_valid", 64'(cmd_valid), 64'd1);
    chk("t1_ch", 64'(cmd_ch), 64'd1);
    chk("t1_data", 64'(cmd_data), 64'h20_0000_00AB);
    chk("t1_action", 64'(cmd_action), 64'd1);
    chk("t1_ir_out", 64'(ir_out), 64'd0);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    chk("t1_valid_drop", 64'(cmd_valid), 64'd0);

    // Capture readback on channel 2, LSB first
    do_uir(2'd2); do_cdr();
    do_shift('0, DR_W, 1'b1, cap2);
    chk("t2_tdo_tail", 64'(tdo), 64'd0);

    // Short and overlong scans raise scan_err; vs_uir clears it
    do_uir(2'd1); do_cdr();
    do_shift(d_a, DR_W - 1, 1'b0, '0);
    do_udr(1'b0, '0, '0);
    chk("t3_short_valid", 64'(cmd_valid), 64'd0);
    chk("t3_short_ir_out", 64'(ir_out), 64'd2);
    do_uir(2'd1);
    chk("t3_clr_ir_out", 64'(ir_out), 64'd0);
    do_cdr();
    do_shift(d_a, DR_W + 1, 1'b0, '0);
    do_udr(1'b0, '0, '0);
    chk("t3_long_valid", 64'(cmd_valid), 64'd0);
    chk("t3_long_ir_out", 64'(ir_out), 64'd2);

    // Overrun: second update while first is unaccepted
    do_uir(2'd0); do_cdr();
    do_shift(d_a, DR_W, 1'b0, '0);
    do_udr(1'b1, d_a, 2'd0);
    do_cdr();
    do_shift(d_b, DR_W, 1'b0, '0);
    do_udr(1'b0, '0, '0);
    chk("t4_hold_valid", 64'(cmd_valid), 64'd1);
    chk("t4_hold_data", 64'(cmd_data), 64'(d_a));
    chk("t4_hold_action", 64'(cmd_action), 64'd0);
    chk("t4_ovr_ir_out", 64'(ir_out), 64'd1);
    do_uir(2'd0);
    chk("t4_clr_ir_out", 64'(ir_out), 64'd0);
    chk("t4_still_valid", 64'(cmd_valid), 64'd1);
    do_cdr();
    do_shift(d_c, DR_W, 1'b0, '0);
    cmd_ready = 1'b1;
    do_udr(1'b1, d_c, 2'd0);
    chk("t4_b2b_valid", 64'(cmd_valid), 64'd1);
    chk("t4_b2b_data", 64'(cmd_data), 64'(d_c));
    chk("t4_b2b_action", 64'(cmd_action), 64'd1);
    chk("t4_b2b_ir_out", 64'(ir_out), 64'd0);
    tick(); cmd_ready = 1'b0;
    chk("t4_done_valid", 64'(cmd_valid), 64'd0);

    // Bypass channel: capture 0, update ignored without flags
    do_uir(2'd3); do_cdr();
    chk("t5_byp_tdo", 64'(tdo), 64'd0);
    do_shift(d_d, DR_W, 1'b0, '0);
    do_udr(1'b0, '0, '0);
    chk("t5_byp_valid", 64'(cmd_valid), 64'd0);
    chk("t5_byp_ir_out", 64'(ir_out), 64'd0);

    // Reset mid-shift with a command pending and a flag set
    do_uir(2'd1); do_cdr();
    do_shift(d_d, DR_W, 1'b0, '0);
    do_udr(1'b0, '0, '0);
    chk("t5_pend_valid", 64'(cmd_valid), 64'd1);
    do_cdr();
    do_shift(d_d, 5, 1'b0, '0);
    do_udr(1'b0, '0, '0);
    chk("t5_serr_ir_out", 64'(ir_out), 64'd2);
    do_cdr();
    do_shift(d_d, 3, 1'b0, '0);
    chk("t5_pre_tdo", 64'(tdo), 64'(cap1[3]));
    vs_sdr = 1'b1; tdi = 1'b1; reset = 1'b1;
    tick();
    vs_sdr = 1'b0; reset = 1'b0;
    chk("t5_rst_tdo", 64'(tdo), 64'd0);
    chk("t5_rst_ir_out", 64'(ir_out), 64'd0);
    chk("t5_rst_valid", 64'(cmd_valid), 64'd0);
    chk("t5_rst_data", 64'(cmd_data), 64'd0);
    chk("t5_rst_ch", 64'(cmd_ch), 64'd0);
    chk("t5_rst_action", 64'(cmd_action), 64'd0);
    tick();
    chk("t5_post_valid", 64'(cmd_valid), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
